// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serial pattern-detect path: serializer state
// encoding and the default word width used by the detector-path top level.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words arrive over valid/ready, pass
// through a one-word holding register, and leave one bit per clock on out_bit.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_e            r_state;
   logic [WIDTH-1:0]  r_sr;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_hold;
   logic              r_hold_full;

   logic              w_last;
   logic              w_load;
   logic              w_accept;

   // Accept and load are mutually exclusive: accept needs hold empty, load needs it full.
   always_comb begin
      w_last     = 1'b0;
      w_load     = 1'b0;
      w_accept   = 1'b0;
      data_ready = 1'b0;
      out_bit    = IDLE_BIT;
      out_valid  = 1'b0;
      busy       = 1'b0;
      word_done  = 1'b0;

      w_last     = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
      w_load     = r_hold_full && ((r_state == ST_IDLE) || w_last);
      data_ready = !r_hold_full;
      w_accept   = data_valid && !r_hold_full;

      if (r_state == ST_SHIFT) begin
         out_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
      end
      out_valid = (r_state == ST_SHIFT);
      busy      = (r_state == ST_SHIFT) || r_hold_full;
      word_done = w_last;
   end

   // NOTE: every register, including the hold data, is cleared by reset so a
   // discarded word can never leak out after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // sees the pre-edge values of the registers it tests.
         if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
         end

         if (w_load) begin
            r_sr        <= r_hold;
            r_cnt       <= '0;
            r_state     <= ST_SHIFT;
            r_hold_full <= 1'b0;
         end else if (r_state == ST_SHIFT) begin
            if (w_last) begin
               r_state <= ST_IDLE;
            end else begin
               r_cnt <= r_cnt + CNT_ONE;
               if (MSB_FIRST) begin
                  r_sr <= {r_sr[WIDTH-2:0], 1'b0};
               end else begin
                  r_sr <= {1'b0, r_sr[WIDTH-1:1]};
               end
            end
         end
      end
   end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: a cycle-indexed timeline model built
// from the word-level timing rules predicts every output on every cycle.
module tb_bit_serializer;

   localparam int W  = 8;
   localparam int NC = 1024;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] din;
   logic         dv;
   logic         sel;   // 0: MSB-first instance, 1: LSB-first instance

   logic m_ready, m_bit, m_valid, m_busy, m_done;
   logic l_ready, l_bit, l_valid, l_busy, l_done;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (din),
      .data_valid (dv & ~sel),
      .data_ready (m_ready),
      .out_bit    (m_bit),
      .out_valid  (m_valid),
      .busy       (m_busy),
      .word_done  (m_done)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (din),
      .data_valid (dv & sel),
      .data_ready (l_ready),
      .out_bit    (l_bit),
      .out_valid  (l_valid),
      .busy       (l_busy),
      .word_done  (l_done)
   );

   int total = 0;
   int bad   = 0;

   // Timeline model: entry k describes the cycle following clock edge k.
   bit e_bit  [NC];
   bit e_val  [NC];
   bit e_done [NC];
   bit e_rdy  [NC];
   bit e_busy [NC];
   int cur;
   int free_c;

   localparam logic [4:0] IDLE_VEC = 5'b00010;   // {bit, valid, done, ready, busy}

   function automatic logic [4:0] obs_vec();
      if (sel) return {l_bit, l_valid, l_done, l_ready, l_busy};
      return {m_bit, m_valid, m_done, m_ready, m_busy};
   endfunction

   function automatic logic [4:0] exp_vec();
      return {e_bit[cur], e_val[cur], e_done[cur], e_rdy[cur], e_busy[cur]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NC; i++) begin
         e_bit[i]  = 1'b0;
         e_val[i]  = 1'b0;
         e_done[i] = 1'b0;
         e_rdy[i]  = 1'b1;
         e_busy[i] = 1'b0;
      end
      cur    = 0;
      free_c = 0;
   endtask

   // Word accepted at edge c: held until its load edge s, then bits occupy s..s+W-1.
   task automatic add_word(input int c, input logic [W-1:0] w, input bit msb);
      int s;
      s = (c + 1 > free_c) ? c + 1 : free_c;
      for (int k = c; k < s; k++) begin
         e_rdy[k]  = 1'b0;
         e_busy[k] = 1'b1;
      end
      for (int i = 0; i < W; i++) begin
         e_val[s+i]  = 1'b1;
         e_busy[s+i] = 1'b1;
         e_bit[s+i]  = msb ? w[W-1-i] : w[i];
      end
      e_done[s+W-1] = 1'b1;
      free_c = s + W;
   endtask

   // Drive inputs for the next edge, record an accept in the model, advance one cycle.
   task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
      dv  = v;
      din = d;
      acc = v && e_rdy[cur];
      if (acc) add_word(cur + 1, d, !sel);
      @(posedge clk);
      cur++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit acc;
      reset_n = 1'b0;
      dv = 1'b0; din = '0; sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== IDLE_VEC) begin
            bad++;
            $display("FAIL reset_hold i=%0d got=%b want=%b", i, obs_vec(), IDLE_VEC);
         end
      end
      reset_n = 1'b1;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step(1'b0, '0, acc);
      end
   endtask

   task automatic test_single();
      bit acc;
      model_clear();
      for (int i = 0; i < 14; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step(i == 0, 8'hA5, acc);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q[$];
      bit acc;
      model_clear();
      q.push_back(8'h05);
      q.push_back(8'hA0);
      for (int i = 0; i < 40; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         if (q.size() != 0) begin
            step(1'b1, q[0], acc);
            if (acc) void'(q.pop_front());
         end else begin
            step(1'b0, '0, acc);
         end
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain left=%0d want=0", q.size());
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      model_clear();
      for (int i = 0; i < 60; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL backpressure cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step(i < 40, W'($urandom), acc);
      end
   endtask

   task automatic test_random();
      bit acc;
      model_clear();
      for (int i = 0; i < 300; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step((i < 280) && ($urandom_range(0, 2) == 0), W'($urandom), acc);
      end
   endtask

   task automatic test_lsb_first();
      bit acc;
      sel = 1'b1;
      model_clear();
      for (int i = 0; i < 120; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL lsb cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         if (i == 0) step(1'b1, 8'h01, acc);
         else step((i > 12) && (i < 100) && $urandom_range(0, 1) == 1, W'($urandom), acc);
      end
      dv  = 1'b0;
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      bit acc;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL midrst_pre cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step(i == 0, 8'hFF, acc);
      end
      // Three bits of 8'hFF have now been on the line; reset lands mid-word.
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs_vec() !== IDLE_VEC) begin
            bad++;
            $display("FAIL midrst_hold i=%0d got=%b want=%b", i, obs_vec(), IDLE_VEC);
         end
         @(negedge clk);
      end
      reset_n = 1'b1;
      model_clear();
      for (int i = 0; i < 14; i++) begin
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL midrst_post cyc=%0d got=%b want=%b", cur, obs_vec(), exp_vec());
         end
         step(i == 0, 8'h80, acc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_lsb_first();
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bit_serializer
